// File: rtl/linear_network_gather_seq_if.sv
// ---------------------------------------------------------------------------
// linear_network_gather_seq_if
//   Bundle of the injection side and the single output side of the gather
//   chain.
//
//   Handshake: node k's word is transferred at a rising edge when
//   i_valid[k] and o_ready[k] are both high at that edge. While i_valid[k] is
//   high and o_ready[k] is low, the node holds i_valid[k] and its data slice
//   unchanged. The output side has no ready: o_valid/o_data_bus/o_src are
//   presented for exactly one enabled cycle and the consumer must take them.
//
//   Signals:
//     i_valid    [NUM_NODE]             per-node inject request
//     i_data_bus [NUM_NODE*DATA_WIDTH]  node k word at [k*DATA_WIDTH +: DATA_WIDTH]
//     o_ready    [NUM_NODE]             per-node accept (combinational)
//     i_en       [1]                    chain enable, low freezes everything
//     o_valid    [1]                    output word valid
//     o_data_bus [DATA_WIDTH]           output word
//     o_src      [SRC_WIDTH]            source node of the output word
//
//   Modports: master = node/consumer side (drives inputs),
//             slave  = the chain itself.
// ---------------------------------------------------------------------------
interface linear_network_gather_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4,
    parameter int SRC_WIDTH  = $clog2(NUM_NODE)
);
    logic [NUM_NODE-1:0]            i_valid;
    logic [NUM_NODE*DATA_WIDTH-1:0] i_data_bus;
    logic [NUM_NODE-1:0]            o_ready;
    logic                           i_en;
    logic                           o_valid;
    logic [DATA_WIDTH-1:0]          o_data_bus;
    logic [SRC_WIDTH-1:0]           o_src;

    modport master (
        output i_valid, i_data_bus, i_en,
        input  o_ready, o_valid, o_data_bus, o_src
    );

    modport slave (
        input  i_valid, i_data_bus, i_en,
        output o_ready, o_valid, o_data_bus, o_src
    );
endinterface

// File: rtl/linear_network_gather_seq.sv
// ---------------------------------------------------------------------------
// linear_network_gather_seq
//   Many-to-one linear collection chain. NUM_NODE stages, each holding a
//   {valid, data, src} triple. Words shift one stage toward node 0 per enabled
//   cycle and leave through stage 0 tagged with their source node. Traffic
//   already in the chain has fixed priority over local injection, so a node
//   can only inject when the stage above it is empty.
//
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset, overrides everything
//     bus  - linear_network_gather_seq_if.slave (inject side + output side)
//
//   NUM_NODE must be at least 2.
// ---------------------------------------------------------------------------
module linear_network_gather_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4,
    parameter int SRC_WIDTH  = $clog2(NUM_NODE)
) (
    input  logic clk,
    input  logic rst,
    linear_network_gather_seq_if.slave bus
);

    logic [NUM_NODE-1:0]   v_q, v_d;
    logic [DATA_WIDTH-1:0] d_q [NUM_NODE];
    logic [DATA_WIDTH-1:0] d_d [NUM_NODE];
    logic [SRC_WIDTH-1:0]  s_q [NUM_NODE];
    logic [SRC_WIDTH-1:0]  s_d [NUM_NODE];
    logic [NUM_NODE-1:0]   ready_w;

    // A node is accepted only when the stage above it is empty; the top node
    // has nothing above it. Ready is forced low in reset and while frozen.
    always_comb begin
        ready_w = '0;
        for (int k = 0; k < NUM_NODE - 1; k++) begin
            ready_w[k] = ~rst & bus.i_en & ~v_q[k+1];
        end
        ready_w[NUM_NODE-1] = ~rst & bus.i_en;
    end

    // Stage next-state: pass-through beats inject beats bubble. Bubbles carry
    // all-zero data and source so an idle output reads as zero.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        s_d = s_q;
        if (bus.i_en) begin
            for (int k = 0; k < NUM_NODE - 1; k++) begin
                if (v_q[k+1]) begin
                    v_d[k] = 1'b1;
                    d_d[k] = d_q[k+1];
                    s_d[k] = s_q[k+1];
                end else if (bus.i_valid[k]) begin
                    v_d[k] = 1'b1;
                    d_d[k] = bus.i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
                    s_d[k] = SRC_WIDTH'(k);
                end else begin
                    v_d[k] = 1'b0;
                    d_d[k] = '0;
                    s_d[k] = '0;
                end
            end
            if (bus.i_valid[NUM_NODE-1]) begin
                v_d[NUM_NODE-1] = 1'b1;
                d_d[NUM_NODE-1] = bus.i_data_bus[(NUM_NODE-1)*DATA_WIDTH +: DATA_WIDTH];
                s_d[NUM_NODE-1] = SRC_WIDTH'(NUM_NODE - 1);
            end else begin
                v_d[NUM_NODE-1] = 1'b0;
                d_d[NUM_NODE-1] = '0;
                s_d[NUM_NODE-1] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < NUM_NODE; k++) begin
                d_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            d_q <= d_d;
            s_q <= s_d;
        end
    end

    assign bus.o_ready    = ready_w;
    assign bus.o_valid    = v_q[0];
    assign bus.o_data_bus = d_q[0];
    assign bus.o_src      = s_q[0];

endmodule

// File: tb/tb_linear_network_gather_seq.sv
// ---------------------------------------------------------------------------
// tb_linear_network_gather_seq
//   Bench for linear_network_gather_seq (NUM_NODE=4, DATA_WIDTH=32).
//   Reference model: slot reservation. A word accepted from node k at enabled
//   edge c leaves the chain at enabled edge c+k; node k is ready before edge c
//   when no word is booked to exit at edge c+k (that word would be sitting in
//   stage k+1).
// ---------------------------------------------------------------------------
module tb_linear_network_gather_seq;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    typedef struct packed {
        logic [SW-1:0] src;
        logic [DW-1:0] data;
    } word_t;

    typedef struct {
        logic          rst;
        logic          en;
        logic [N-1:0]  vld;
        logic [N*DW-1:0] data;
        logic [N-1:0]  rdy;
        logic          ovld;
        logic [DW-1:0] odata;
        logic [SW-1:0] osrc;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    linear_network_gather_seq_if #(.DATA_WIDTH(DW), .NUM_NODE(N), .SRC_WIDTH(SW)) bus ();

    linear_network_gather_seq #(.DATA_WIDTH(DW), .NUM_NODE(N), .SRC_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard / model ----------------
    int checks;
    int errors;

    word_t         exit_at [int];
    int            edge_idx;
    logic          m_vld;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_src;
    logic [N-1:0]  last_rdy;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_ready(input logic r, input logic e);
        logic [N-1:0] rd;
        rd = '0;
        if (!r && e) begin
            for (int k = 0; k < N; k++) begin
                rd[k] = !exit_at.exists(edge_idx + 1 + k);
            end
        end
        return rd;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic [N-1:0] v,
                              input logic [N*DW-1:0] d, input logic [N-1:0] rdy);
        int    c;
        word_t w;
        if (r) begin
            exit_at.delete();
            edge_idx = 0;
            m_vld    = 1'b0;
            m_data   = '0;
            m_src    = '0;
        end else if (e) begin
            c = edge_idx + 1;
            for (int k = 0; k < N; k++) begin
                if (v[k] && rdy[k]) begin
                    w.src  = SW'(k);
                    w.data = d[k*DW +: DW];
                    exit_at[c + k] = w;
                end
            end
            if (exit_at.exists(c)) begin
                m_vld  = 1'b1;
                m_data = exit_at[c].data;
                m_src  = exit_at[c].src;
                exit_at.delete(c);
            end else begin
                m_vld  = 1'b0;
                m_data = '0;
                m_src  = '0;
            end
            edge_idx = c;
        end
    endtask

    // ---------------- driver ----------------
    // Drive one cycle, check ready before the edge and outputs after it.
    task automatic step(input logic r, input logic e, input logic [N-1:0] v, input logic [N*DW-1:0] d);
        rst            = r;
        bus.i_en       = e;
        bus.i_valid    = v;
        bus.i_data_bus = d;
        #1;
        last_rdy = model_ready(r, e);
        check("ready", DW'(bus.o_ready), DW'(last_rdy));
        @(posedge clk);
        model_edge(r, e, v, d, last_rdy);
        #1;
        check("o_valid", DW'(bus.o_valid), DW'(m_vld));
        check("o_data", bus.o_data_bus, m_data);
        check("o_src", DW'(bus.o_src), DW'(m_src));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, '0, '0);
    endtask

    // ---------------- test ----------------
    vec_t tbl [7];

    initial begin
        logic [N-1:0]    pv;
        logic [DW-1:0]   pd [N];
        logic [N*DW-1:0] db;
        int              src_seq [8];
        logic [N-1:0]    rdy_seq [8];
        logic            held_v;
        logic [DW-1:0]   held_d;
        logic            r;
        logic            e;

        checks   = 0;
        errors   = 0;
        edge_idx = 0;
        m_vld    = 1'b0;
        m_data   = '0;
        m_src    = '0;

        // Reset, single injection from node 2 (3-clock latency), node 0 (1 clock).
        tbl[0] = '{1'b1, 1'b1, 4'b1111, {4{32'hDEADBEEF}}, 4'b0000, 1'b0, 32'h0, 2'd0};
        tbl[1] = '{1'b1, 1'b1, 4'b1111, {4{32'hDEADBEEF}}, 4'b0000, 1'b0, 32'h0, 2'd0};
        tbl[2] = '{1'b0, 1'b1, 4'b0100, {32'h0, 32'hAAAAAAAA, 64'h0}, 4'b1111, 1'b0, 32'h0, 2'd0};
        tbl[3] = '{1'b0, 1'b1, 4'b0000, 128'h0, 4'b1101, 1'b0, 32'h0, 2'd0};
        tbl[4] = '{1'b0, 1'b1, 4'b0000, 128'h0, 4'b1110, 1'b1, 32'hAAAAAAAA, 2'd2};
        tbl[5] = '{1'b0, 1'b1, 4'b0001, {96'h0, 32'hBBBBBBBB}, 4'b1111, 1'b1, 32'hBBBBBBBB, 2'd0};
        tbl[6] = '{1'b0, 1'b1, 4'b0000, 128'h0, 4'b1111, 1'b0, 32'h0, 2'd0};

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].vld, tbl[i].data);
            check("tbl_ready", DW'(last_rdy), DW'(tbl[i].rdy));
            check("tbl_o_valid", DW'(bus.o_valid), DW'(tbl[i].ovld));
            check("tbl_o_data", bus.o_data_bus, tbl[i].odata);
            check("tbl_o_src", DW'(bus.o_src), DW'(tbl[i].osrc));
        end

        // All nodes valid continuously from an empty chain.
        src_seq = '{0, 1, 2, 3, 3, 3, 3, 3};
        rdy_seq = '{4'b1111, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
        db = {32'h30000003, 32'h20000002, 32'h10000001, 32'h00000000};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 4'b1111, db);
            check("allv_ready", DW'(last_rdy), DW'(rdy_seq[i]));
            check("allv_src", DW'(bus.o_src), DW'(src_seq[i]));
        end

        // Mid-flight reset with the chain full: nothing stale may come out.
        step(1'b1, 1'b1, 4'b0000, '0);
        check("midrst_o_valid", DW'(bus.o_valid), 32'h0);
        idle(6);

        // Bubble fill: node 3 once, node 1 requests two cycles later and holds.
        step(1'b0, 1'b1, 4'b1000, {32'h33333333, 96'h0});
        idle(1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 4'b0010, {64'h0, 32'h11111111, 32'h0});
            if (last_rdy[1]) break;
        end
        check("bubble_accepted", DW'(last_rdy[1]), 32'h1);
        idle(5);

        // Enable freeze with words from nodes 1 and 3 in flight.
        step(1'b0, 1'b1, 4'b1010, {32'h3C3C3C3C, 32'h0, 32'h1C1C1C1C, 32'h0});
        held_v = bus.o_valid;
        held_d = bus.o_data_bus;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'($urandom_range(0, 15)), {$urandom(), $urandom(), $urandom(), $urandom()});
            check("freeze_o_valid", DW'(bus.o_valid), DW'(held_v));
            check("freeze_o_data", bus.o_data_bus, held_d);
        end
        idle(5);

        // Randomized traffic: senders hold until accepted.
        pv = '0;
        for (int k = 0; k < N; k++) pd[k] = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (!pv[k] && $urandom_range(0, 2) == 0) begin
                    pv[k] = 1'b1;
                    pd[k] = $urandom();
                end
            end
            for (int k = 0; k < N; k++) db[k*DW +: DW] = pd[k];
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 7) != 0);
            step(r, e, pv, db);
            for (int k = 0; k < N; k++) begin
                if (last_rdy[k]) pv[k] = 1'b0;
            end
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
